// File: rtl/snow64_int_vector_caster.sv
// snow64_int_vector_caster
//
// Converts a packed vector of integer elements from one element size and
// signedness to another, one destination element per clock.
//
// Elements are packed with element k at bits [k*bits +: bits], so element 0
// sits in the LSBs. Each destination element i takes source element i, widens
// it to 64 bits (signed or zero extension from the source signedness), then
// resizes it to the destination width. Destination slots that have no
// matching source element are zero. Source elements beyond the destination
// count are dropped.
//
// Optional feature, selected by the SNOW64_CPU_CAST_SATURATE_EN macro:
//   undefined : each element is the low dst_bits of the widened value
//   defined   : each element clamps to the destination range, using the
//               destination signedness
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   synchronous active-low reset
//   in_valid        in   request present
//   in_ready        out  block can accept a request (IDLE only)
//   in_data         in   source vector, VEC_WIDTH bits
//   in_src_type     in   source type: 0 unsigned, 1 signed, 2 bfloat16, 3 reserved
//   in_src_int_size in   source element size: 0/1/2/3 = 8/16/32/64 bits
//   in_dst_type     in   destination type code
//   in_dst_int_size in   destination element size code
//   out_valid       out  result present (DONE only)
//   out_ready       in   consumer takes the result
//   out_data        out  result vector, VEC_WIDTH bits
//   out_err         out  unsupported type; result is zero
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// BUSY  | producing one destination element per cycle (or flagging error)
// DONE  | result held on out_data/out_err until out_ready

module snow64_int_vector_caster #(
    parameter int VEC_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VEC_WIDTH-1:0] in_data,
    input  logic [1:0]           in_src_type,
    input  logic [1:0]           in_src_int_size,
    input  logic [1:0]           in_dst_type,
    input  logic [1:0]           in_dst_int_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VEC_WIDTH-1:0] out_data,
    output logic                 out_err
);

    // Counter must hold element counts up to VEC_WIDTH/8 inclusive.
    localparam int CNT_W = $clog2(VEC_WIDTH / 8) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [VEC_WIDTH-1:0] data_q;
    logic [1:0]           src_size_q;
    logic [1:0]           dst_size_q;
    logic                 src_sgn_q;
    logic                 type_err_q;
    logic [VEC_WIDTH-1:0] res_q;
    logic [VEC_WIDTH-1:0] res_d;
    logic                 err_q;

    logic [6:0]           src_bits;
    logic [6:0]           dst_bits;
    logic [CNT_W-1:0]     n_src;
    logic [CNT_W-1:0]     n_dst;
    logic [63:0]          dst_mask;
    logic [15:0]          src_sh;
    logic [15:0]          dst_sh;
    logic [63:0]          src_word;
    logic [63:0]          ext;
    logic [63:0]          elem;

`ifdef SNOW64_CPU_CAST_SATURATE_EN
    logic                 dst_sgn_q;
    logic signed [64:0]   val;
    logic signed [64:0]   dmax;
    logic signed [64:0]   dmin;
    logic signed [64:0]   sat;
`else
    // Truncation does not depend on destination signedness.
    logic                 unused_dst_sgn;
    assign unused_dst_sgn = in_dst_type[0];
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_err   = err_q;

    always_comb begin
        src_bits = 7'd8;
        n_src    = CNT_W'(VEC_WIDTH / 8);
        case (src_size_q)
            2'd0:    begin src_bits = 7'd8;  n_src = CNT_W'(VEC_WIDTH / 8);  end
            2'd1:    begin src_bits = 7'd16; n_src = CNT_W'(VEC_WIDTH / 16); end
            2'd2:    begin src_bits = 7'd32; n_src = CNT_W'(VEC_WIDTH / 32); end
            default: begin src_bits = 7'd64; n_src = CNT_W'(VEC_WIDTH / 64); end
        endcase

        dst_bits = 7'd8;
        n_dst    = CNT_W'(VEC_WIDTH / 8);
        dst_mask = 64'h0000_0000_0000_00FF;
        case (dst_size_q)
            2'd0: begin
                dst_bits = 7'd8;  n_dst = CNT_W'(VEC_WIDTH / 8);
                dst_mask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                dst_bits = 7'd16; n_dst = CNT_W'(VEC_WIDTH / 16);
                dst_mask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                dst_bits = 7'd32; n_dst = CNT_W'(VEC_WIDTH / 32);
                dst_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                dst_bits = 7'd64; n_dst = CNT_W'(VEC_WIDTH / 64);
                dst_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    // Element extraction and widening for the current counter position.
    always_comb begin
        src_sh   = 16'(cnt_q) * 16'(src_bits);
        dst_sh   = 16'(cnt_q) * 16'(dst_bits);
        src_word = 64'(data_q >> src_sh);
        ext      = src_word;
        case (src_size_q)
            2'd0:    ext = {{56{src_sgn_q & src_word[7]}},  src_word[7:0]};
            2'd1:    ext = {{48{src_sgn_q & src_word[15]}}, src_word[15:0]};
            2'd2:    ext = {{32{src_sgn_q & src_word[31]}}, src_word[31:0]};
            default: ext = src_word;
        endcase
    end

`ifdef SNOW64_CPU_CAST_SATURATE_EN
    // 65-bit signed compare so that unsigned 64-bit sources above 2^63 and
    // an unsigned 64-bit destination maximum are both representable.
    always_comb begin
        val  = {src_sgn_q & ext[63], ext};
        dmax = 65'sd255;
        dmin = 65'sd0;
        case (dst_size_q)
            2'd0: begin
                dmax = dst_sgn_q ? 65'sd127 : 65'sd255;
                dmin = dst_sgn_q ? -65'sd128 : 65'sd0;
            end
            2'd1: begin
                dmax = dst_sgn_q ? 65'sd32767 : 65'sd65535;
                dmin = dst_sgn_q ? -65'sd32768 : 65'sd0;
            end
            2'd2: begin
                dmax = dst_sgn_q ? 65'sd2147483647 : 65'sd4294967295;
                dmin = dst_sgn_q ? -65'sd2147483648 : 65'sd0;
            end
            default: begin
                dmax = dst_sgn_q ? 65'sh0_7FFF_FFFF_FFFF_FFFF : 65'sh0_FFFF_FFFF_FFFF_FFFF;
                dmin = dst_sgn_q ? 65'sh1_8000_0000_0000_0000 : 65'sd0;
            end
        endcase
        if (val > dmax) begin
            sat = dmax;
        end else if (val < dmin) begin
            sat = dmin;
        end else begin
            sat = val;
        end
        elem = (cnt_q < n_src) ? (sat[63:0] & dst_mask) : 64'd0;
    end
`else
    always_comb begin
        elem = (cnt_q < n_src) ? (ext & dst_mask) : 64'd0;
    end
`endif

    // Result is cleared on accept, so each new element can simply be OR-ed in.
    assign res_d = res_q | (VEC_WIDTH'(elem) << dst_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            src_size_q <= 2'd0;
            dst_size_q <= 2'd0;
            src_sgn_q  <= 1'b0;
            type_err_q <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        src_size_q <= in_src_int_size;
                        dst_size_q <= in_dst_int_size;
                        src_sgn_q  <= in_src_type[0];
                        type_err_q <= in_src_type[1] | in_dst_type[1];
                        cnt_q      <= '0;
                        res_q      <= '0;
                        err_q      <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (type_err_q) begin
                        err_q   <= 1'b1;
                        res_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        res_q <= res_d;
                        if (cnt_q == n_dst - CNT_W'(1)) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SNOW64_CPU_CAST_SATURATE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dst_sgn_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            dst_sgn_q <= in_dst_type[0];
        end
    end
`endif

endmodule
